// File: rtl/clk_enable_scheduler.sv
// Multi-channel clock-enable generator with a valid/ready configuration port.
// Channel retunes and stops are deferred to the channel's period boundary so no runt period is emitted.
module clk_enable_scheduler #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 16,
    parameter int CH_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CfgValid,
    output logic                 CfgReady,
    input  logic [CH_WIDTH-1:0]  CfgChannel,
    input  logic [DIV_WIDTH-1:0] CfgDivisor,
    input  logic                 CfgEnable,
    output logic                 CfgError,
    output logic [CHANNELS-1:0]  ClkEnableOutput,
    output logic [CHANNELS-1:0]  ClkOutput,
    output logic [CHANNELS-1:0]  Running
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [CH_WIDTH:0]    LP_CH_LIMIT = (CH_WIDTH + 1)'(CHANNELS);
    localparam logic [DIV_WIDTH-1:0] LP_MIN_DIV  = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] LP_ONE      = DIV_WIDTH'(1);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_error;
    logic [CH_WIDTH-1:0]  r_cfg_ch;
    logic [DIV_WIDTH-1:0] r_cfg_div;
    logic                 r_cfg_en;

    logic [DIV_WIDTH-1:0] r_div   [CHANNELS];
    logic [DIV_WIDTH-1:0] r_count [CHANNELS];
    logic [CHANNELS-1:0]  r_running;
    logic [CHANNELS-1:0]  r_cen;
    logic [CHANNELS-1:0]  r_clk;

    logic                 w_accept;
    logic                 w_bad_req;
    logic [CHANNELS-1:0]  w_target;
    logic [CHANNELS-1:0]  w_at_end;
    logic [CHANNELS-1:0]  w_apply;
    logic [DIV_WIDTH-1:0] w_div_nxt   [CHANNELS];
    logic [DIV_WIDTH-1:0] w_count_nxt [CHANNELS];
    logic [CHANNELS-1:0]  w_run_nxt;

    assign w_accept  = CfgValid && r_ready;
    assign w_bad_req = ({1'b0, CfgChannel} >= LP_CH_LIMIT) ||
                       (CfgEnable && (CfgDivisor < LP_MIN_DIV));

    // A pending request lands only on a stopped channel or on the last cycle of a running period.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_target[i]    = (r_state == S_WAIT) && (r_cfg_ch == CH_WIDTH'(i));
            w_at_end[i]    = r_running[i] && (r_count[i] == (r_div[i] - LP_ONE));
            w_apply[i]     = w_target[i] && (!r_running[i] || w_at_end[i]);

            w_div_nxt[i]   = r_div[i];
            w_count_nxt[i] = r_count[i];
            w_run_nxt[i]   = r_running[i];

            if (r_running[i]) begin
                w_count_nxt[i] = w_at_end[i] ? '0 : (r_count[i] + LP_ONE);
            end

            if (w_apply[i]) begin
                if (r_cfg_en) begin
                    w_div_nxt[i] = r_cfg_div;
                    w_run_nxt[i] = 1'b1;
                    if (!r_running[i]) begin
                        w_count_nxt[i] = '0;
                    end
                end else begin
                    w_run_nxt[i]   = 1'b0;
                    w_count_nxt[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_error   <= 1'b0;
            r_cfg_ch  <= '0;
            r_cfg_div <= '0;
            r_cfg_en  <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (w_bad_req) begin
                        r_error <= 1'b1;
                    end else begin
                        r_state   <= S_WAIT;
                        r_ready   <= 1'b0;
                        r_cfg_ch  <= CfgChannel;
                        r_cfg_div <= CfgDivisor;
                        r_cfg_en  <= CfgEnable;
                    end
                end
            end else if (|w_apply) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
            end
        end
    end

    // Outputs are registered from the next-state count so they line up with the cycle that owns that count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_div[i]   <= '0;
                r_count[i] <= '0;
            end
            r_running <= '0;
            r_cen     <= '0;
            r_clk     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_div[i]     <= w_div_nxt[i];
                r_count[i]   <= w_count_nxt[i];
                r_running[i] <= w_run_nxt[i];
                r_cen[i]     <= w_run_nxt[i] && (w_count_nxt[i] == '0);
                r_clk[i]     <= w_run_nxt[i] && (w_count_nxt[i] < (w_div_nxt[i] >> 1));
            end
        end
    end

    assign CfgReady        = r_ready;
    assign CfgError        = r_error;
    assign ClkEnableOutput = r_cen;
    assign ClkOutput       = r_clk;
    assign Running         = r_running;

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Scoreboard bench for clk_enable_scheduler with three channels, so channel index 3 is out of range.
module tb_clk_enable_scheduler;

    localparam int CH = 3;
    localparam int DW = 16;
    localparam int CW = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          CfgValid = 1'b0;
    logic          CfgReady;
    logic [CW-1:0] CfgChannel = '0;
    logic [DW-1:0] CfgDivisor = '0;
    logic          CfgEnable = 1'b0;
    logic          CfgError;
    logic [CH-1:0] ClkEnableOutput;
    logic [CH-1:0] ClkOutput;
    logic [CH-1:0] Running;

    clk_enable_scheduler #(
        .CHANNELS (CH),
        .DIV_WIDTH(DW),
        .CH_WIDTH (CW)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .CfgValid       (CfgValid),
        .CfgReady       (CfgReady),
        .CfgChannel     (CfgChannel),
        .CfgDivisor     (CfgDivisor),
        .CfgEnable      (CfgEnable),
        .CfgError       (CfgError),
        .ClkEnableOutput(ClkEnableOutput),
        .ClkOutput      (ClkOutput),
        .Running        (Running)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int p0_q[$];
    bit any_pulse;

    // Reference model state
    bit m_run[CH];
    int m_div[CH];
    int m_cnt[CH];
    bit m_wait, m_err, m_en;
    int m_ch, m_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_div[i] = 0; m_cnt[i] = 0;
        end
        m_wait = 0; m_err = 0; m_en = 0; m_ch = 0; m_d = 0;
    endtask

    task automatic model_edge();
        bit acc, applied, bad, last, tgt;
        acc = CfgValid && !m_wait;
        applied = 0;
        for (int i = 0; i < CH; i++) begin
            last = m_run[i] && (m_cnt[i] == m_div[i] - 1);
            tgt  = m_wait && (m_ch == i) && (!m_run[i] || last);
            if (m_run[i]) m_cnt[i] = last ? 0 : m_cnt[i] + 1;
            if (tgt) begin
                applied = 1;
                if (m_en) begin
                    if (!m_run[i]) m_cnt[i] = 0;
                    m_div[i] = m_d;
                    m_run[i] = 1;
                end else begin
                    m_run[i] = 0;
                    m_cnt[i] = 0;
                end
            end
        end
        m_err = 0;
        if (m_wait) begin
            if (applied) m_wait = 0;
        end else if (acc) begin
            bad = (int'(CfgChannel) >= CH) || (CfgEnable && (int'(CfgDivisor) < 2));
            if (bad) m_err = 1;
            else begin
                m_wait = 1; m_ch = int'(CfgChannel); m_d = int'(CfgDivisor); m_en = CfgEnable;
            end
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [CH-1:0] r, c, e;
        for (int i = 0; i < CH; i++) begin
            r[i] = m_run[i];
            e[i] = m_run[i] && (m_cnt[i] == 0);
            c[i] = m_run[i] && (m_cnt[i] < m_div[i] / 2);
        end
        return {21'b0, !m_wait, m_err, r, c, e};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {21'b0, CfgReady, CfgError, Running, ClkOutput, ClkEnableOutput};
    endfunction

    task automatic tick();
        model_edge();
        exp_q.push_back(model_vec());
        @(negedge Clk);
        cyc++;
        chk($sformatf("cyc%0d", cyc), dut_vec(), exp_q.pop_front());
        if (ClkEnableOutput[0]) p0_q.push_back(cyc);
        if (|ClkEnableOutput) any_pulse = 1;
    endtask

    task automatic send(input int ch, input int d, input bit en);
        int guard;
        guard = 0;
        CfgChannel = CW'(ch); CfgDivisor = DW'(d); CfgEnable = en; CfgValid = 1'b1;
        while (!CfgReady && guard < 100) begin
            tick();
            guard++;
        end
        chk("send_ready", {31'b0, CfgReady}, 32'd1);
        tick();
        CfgValid = 1'b0;
    endtask

    task automatic wait_ready(output int lowc);
        lowc = 0;
        while (!CfgReady && lowc < 100) begin
            lowc++;
            tick();
        end
    endtask

    function automatic int gap(input int k);
        return (p0_q.size() > k) ? p0_q[k] - p0_q[k-1] : -1;
    endfunction

    initial begin
        logic [7:0] pat_clk, pat_cen;
        int lowc, badgaps;
        int rej_ch[2];
        int rej_d[2];

        model_reset();
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("rst_ready", {31'b0, CfgReady}, 32'd1);
        chk("rst_outputs", dut_vec(), 32'h400);
        @(negedge Clk);
        Reset = 1'b0;

        // Start ch0 at D=4
        tick();
        send(0, 4, 1);
        chk("start_rdy_low", {31'b0, CfgReady}, 32'd0);
        tick();
        chk("start_rdy_back", {31'b0, CfgReady}, 32'd1);
        chk("start_first_pulse", {31'b0, ClkEnableOutput[0]}, 32'd1);
        chk("start_clk_high", {31'b0, ClkOutput[0]}, 32'd1);
        chk("start_running", {31'b0, Running[0]}, 32'd1);
        pat_clk = {7'b0, ClkOutput[0]};
        pat_cen = {7'b0, ClkEnableOutput[0]};
        for (int i = 0; i < 7; i++) begin
            tick();
            pat_clk = {pat_clk[6:0], ClkOutput[0]};
            pat_cen = {pat_cen[6:0], ClkEnableOutput[0]};
        end
        chk("start_clk_pattern", {24'b0, pat_clk}, 32'hCC);
        chk("start_cen_pattern", {24'b0, pat_cen}, 32'h88);

        // Retune ch0 to D=6 while Count=1
        p0_q.delete();
        tick();
        tick();
        send(0, 6, 1);
        wait_ready(lowc);
        chk("retune_rdy_low_cycles", lowc, 32'd2);
        for (int i = 0; i < 12; i++) tick();
        chk("retune_gap_old", gap(1), 32'd4);
        chk("retune_gap_new1", gap(2), 32'd6);
        chk("retune_gap_new2", gap(3), 32'd6);

        // Start ch1 at D=5, then stop it
        p0_q.delete();
        send(1, 5, 1);
        wait_ready(lowc);
        for (int i = 0; i < 7; i++) tick();
        send(1, 0, 0);
        wait_ready(lowc);
        chk("stop_wait_bounded", {31'b0, (lowc >= 1 && lowc <= 5)}, 32'd1);
        chk("stop_running1", {31'b0, Running[1]}, 32'd0);
        chk("stop_cen1", {31'b0, ClkEnableOutput[1]}, 32'd0);
        chk("stop_clk1", {31'b0, ClkOutput[1]}, 32'd0);
        chk("stop_ch0_alive", {31'b0, Running[0]}, 32'd1);
        for (int i = 0; i < 14; i++) tick();
        badgaps = 0;
        for (int k = 1; k < p0_q.size(); k++) if (p0_q[k] - p0_q[k-1] != 6) badgaps++;
        chk("ch0_pulse_count", {31'b0, (p0_q.size() >= 3)}, 32'd1);
        chk("ch0_gaps_undisturbed", badgaps, 32'd0);

        // Rejected requests: divisor too small, channel out of range
        rej_ch[0] = 2; rej_d[0] = 1;
        rej_ch[1] = 3; rej_d[1] = 5;
        for (int r = 0; r < 2; r++) begin
            CfgChannel = CW'(rej_ch[r]); CfgDivisor = DW'(rej_d[r]); CfgEnable = 1'b1; CfgValid = 1'b1;
            tick();
            CfgValid = 1'b0;
            chk($sformatf("rej%0d_error", r), {31'b0, CfgError}, 32'd1);
            chk($sformatf("rej%0d_ready", r), {31'b0, CfgReady}, 32'd1);
            tick();
            chk($sformatf("rej%0d_error_clear", r), {31'b0, CfgError}, 32'd0);
            chk($sformatf("rej%0d_no_start", r), {31'b0, Running[2]}, 32'd0);
        end

        // Reset while a retune on ch2 is pending
        send(2, 5, 1);
        wait_ready(lowc);
        for (int i = 0; i < 3; i++) tick();
        send(2, 8, 1);
        chk("pend_rdy_low", {31'b0, CfgReady}, 32'd0);
        #3 Reset = 1'b1;
        #1;
        chk("rst_async_outputs", {23'b0, Running, ClkOutput, ClkEnableOutput}, 32'd0);
        chk("rst_async_ready", {31'b0, CfgReady}, 32'd1);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        exp_q.delete();
        any_pulse = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_no_pulses", {31'b0, any_pulse}, 32'd0);
        chk("post_rst_ch2_stopped", {31'b0, Running[2]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
